// File: rtl/clk_div_multi_pkg.sv
// Shared constants for the multi-channel clock divider.
package clk_div_multi_pkg;

    // Smallest divisor that still yields a distinct high and low phase
    localparam int unsigned DIV_MIN  = 2;

    // Board clock and the divisors commonly loaded at reset
    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int unsigned DIV_1KHZ = 100_000;
    localparam int unsigned DIV_SCAN = 500_000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active divisor, sticky error flag and
// registered square-wave / tick outputs.
//   clk_i, reset : clock, asynchronous active-low reset
//   en           : run enable; low forces the counter to zero
//   sync_clr     : synchronous restart (phase alignment), wins over en
//   div, div_load: divisor value and its load strobe
//   clk_o        : divided square wave, high for floor(div/2) cycles
//   tick_o       : one-cycle pulse per divided period
//   div_err      : sticky, last load attempt carried a divisor below DIV_MIN
module clk_div_channel
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEFAULT_DIV = DIV_SCAN
) (
    input  logic             clk_i,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div,
    input  logic             div_load,
    output logic             clk_o,
    output logic             tick_o,
    output logic             div_err
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_p;
    logic             pend_valid;

    logic             wrap_c;
    logic             apply_c;
    logic             legal_c;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_q_nxt;
    logic [CNT_W-1:0] div_p_nxt;
    logic             pend_nxt;
    logic             err_nxt;
    logic             clk_nxt;
    logic             tick_nxt;

    // Next-state: divisor changes only take effect at a period boundary
    // (wrap), while idle, or on a synchronous restart.
    always_comb begin
        wrap_c    = en && (cnt == div_q - CNT_W'(1));
        apply_c   = sync_clr || !en || wrap_c;
        legal_c   = div_load && (div >= CNT_W'(DIV_MIN));
        cnt_nxt   = cnt + CNT_W'(1);
        div_q_nxt = div_q;
        div_p_nxt = div_p;
        pend_nxt  = pend_valid;
        err_nxt   = div_err;
        clk_nxt   = en && !sync_clr && (cnt < (div_q >> 1));
        tick_nxt  = wrap_c && !sync_clr;

        if (apply_c) begin
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
            // A load on the boundary itself bypasses the shadow register
            if (legal_c) begin
                div_q_nxt = div;
            end else if (pend_valid) begin
                div_q_nxt = div_p;
            end
        end else if (legal_c) begin
            div_p_nxt = div;
            pend_nxt  = 1'b1;
        end

        if (div_load) begin
            err_nxt = !legal_c;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            div_p      <= '0;
            pend_valid <= 1'b0;
            div_err    <= 1'b0;
            clk_o      <= 1'b0;
            tick_o     <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            div_q      <= div_q_nxt;
            div_p      <= div_p_nxt;
            pend_valid <= pend_nxt;
            div_err    <= err_nxt;
            clk_o      <= clk_nxt;
            tick_o     <= tick_nxt;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates.
//   clk_i, reset : clock, asynchronous active-low reset
//   en_i         : per-channel run enable
//   sync_clr_i   : synchronous restart of all channels
//   div_i        : per-channel divisor, channel k at [k*CNT_W +: CNT_W]
//   div_load_i   : per-channel load strobe for div_i
//   clk_o        : per-channel divided square wave
//   tick_o       : per-channel one-cycle pulse per divided period
//   div_err_o    : per-channel sticky illegal-divisor flag
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned DEFAULT_DIV = DIV_SCAN
) (
    input  logic                    clk_i,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    sync_clr_i,
    input  logic [NUM_CH*CNT_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       div_load_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       tick_o,
    output logic [NUM_CH-1:0]       div_err_o
);

    // Independent channels sharing only the clock, reset and restart
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i    (clk_i),
            .reset    (reset),
            .en       (en_i[k]),
            .sync_clr (sync_clr_i),
            .div      (div_i[k*CNT_W +: CNT_W]),
            .div_load (div_load_i[k]),
            .clk_o    (clk_o[k]),
            .tick_o   (tick_o[k]),
            .div_err  (div_err_o[k])
        );
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the fixed 1 kHz divider.
- Each channel divides clk_i by a divisor that is programmable at run time. Each channel produces:
  - a 50%-nominal square wave (clk_o), used for display/scan clocks;
  - a single-cycle tick enable (tick_o), used for logic kept in the clk_i domain.
- Divisor updates are glitch-free: they apply only at a period boundary.
- Sits between the board clock and the counter/display logic.

Parameters:
- NUM_CH, 2, number of independent divider channels.
- CNT_W, 20, counter/divisor width in bits.
- DEFAULT_DIV, 500000, divisor loaded at reset. Must be >= 2 and < 2^CNT_W.

Ports:
- clk_i  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en_i  in  NUM_CH  per-channel run enable.
- sync_clr_i  in  1  synchronous restart of all channels (phase alignment).
- div_i  in  NUM_CH*CNT_W  per-channel divisor; channel k occupies bits [k*CNT_W +: CNT_W].
- div_load_i  in  NUM_CH  per-channel load strobe for div_i.
- clk_o  out  NUM_CH  divided square wave, registered.
- tick_o  out  NUM_CH  one-clk_i-cycle pulse per divided period, registered.
- div_err_o  out  NUM_CH  sticky flag: last load attempt was illegal (divisor < 2).

Behaviour:
- Reset (reset=0, asynchronous): per channel, cnt=0; active div_q=DEFAULT_DIV; pending=0; pend_valid=0; clk_o=0; tick_o=0; div_err_o=0.
- Per-channel state:
  - cnt[CNT_W-1:0];
  - div_q (active divisor);
  - div_p plus pend_valid (shadow divisor);
  - err flag.
- Wrap condition: wrap = en_i[k] && cnt == div_q-1.
- Counting, en_i[k]=1: cnt increments each cycle. On wrap, cnt goes to 0. Sequence is 0..div_q-1, so the period is exactly div_q cycles.
- Outputs are registered from pre-update state (1-cycle latency):
  - tick_o <= wrap.
  - clk_o <= en_i[k] && (cnt < div_q>>1).
  - High time = floor(div_q/2) cycles; low time = ceil(div_q/2) cycles. Odd divisors give the extra cycle to the low phase.
- Disabled, en_i[k]=0: cnt is forced to 0. On the next edge, clk_o=0 and tick_o=0. div_q and div_p are retained.
- Re-enable: counting starts at cnt=0. clk_o rises one cycle after en_i goes high.
- Divisor load, div_load_i[k]=1 with div_i slice >= 2:
  - Captured into div_p; pend_valid=1; err cleared.
  - A later load before application overwrites div_p (last write wins).
- Divisor application:
  - div_p is transferred to div_q, and pend_valid cleared, on the cycle where wrap=1, or on any cycle where en_i[k]=0.
  - The current period is never truncated or stretched.
- Load in the same cycle as wrap, or while disabled: div_i is written directly to div_q, bypassing the shadow. Any stale pending value is discarded.
- Illegal load (div_i slice of 0 or 1): ignored. div_q, div_p and pend_valid are unchanged; err is set to 1 and stays set until a legal load.
- sync_clr_i=1: all channels set cnt=0. Next edge gives clk_o=0 and tick_o=0. Pending divisors are applied as if at wrap.
  - Priority: reset > sync_clr_i > en_i > normal count.
- Channels are fully independent except for the shared sync_clr_i.
- Width rule: comparisons are unsigned CNT_W bits. div_q-1 cannot underflow because div_q >= 2 is guaranteed.

Decomposition:
- Shared header/package:
  - DIV_MIN=2;
  - default divisor constants for the board (CLK_HZ=100_000_000, DIV_1KHZ=100000, DIV_SCAN=500000).
- Sub-module clk_div_channel holds one channel: counter, shadow/active divisor, err flag, output registers.
- clk_div_multi instantiates NUM_CH channels with a generate loop and slices div_i.

Test Plan:
1. Reset release, DEFAULT_DIV overridden to 10, en=1 -> tick_o pulses every 10 cycles; clk_o high 5 / low 5; first clk_o high 1 cycle after enable.
2. div=7 loaded while disabled, then enable -> tick_o period 7; clk_o high 3 / low 4.
3. Running at div=8; load 4 at cnt=2 -> remaining period completes at 8 cycles; every period after is 4; no runt pulse on clk_o.
4. Load div=1, then div=0 -> div_err_o=1; period unchanged. Then load 6 -> div_err_o=0; new period 6 after next wrap.
5. Ch0 div=4 and ch1 div=6 running at different phases; pulse sync_clr_i -> both outputs low next cycle; both tick_o then coincide every 12 cycles.
6. Assert reset mid-period (asynchronous, no clock edge) -> clk_o, tick_o, div_err_o go to 0 immediately; div_q returns to DEFAULT_DIV.
